// File: rtl/fighter_sprite_renderer.sv
// Fighter sprite pixel pipeline: scan position -> sprite ROM address -> palette RGB, 3-cycle latency.
// Optional hit-flash feature enabled by defining SPRITE_HITFLASH_EN.
module fighter_sprite_renderer #(
  parameter int unsigned SPRITE_W        = 64,
  parameter int unsigned SPRITE_H        = 64,
  parameter int unsigned SCALE_SHIFT     = 1,
  parameter int unsigned NUM_CHARS       = 4,
  parameter int unsigned FRAMES_PER_POSE = 2,
  parameter int unsigned FRAME_TICKS     = 8,
  parameter int unsigned TRANSP_IDX      = 0,
  localparam int unsigned CW     = $clog2(NUM_CHARS),
  localparam int unsigned ROM_AW = $clog2(NUM_CHARS * 9 * FRAMES_PER_POSE * SPRITE_W * SPRITE_H)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        spritex,
  input  logic [9:0]        spritey,
  input  logic              blank,
  input  logic              frame_tick,
  input  logic [CW-1:0]     char_sel,
  input  logic              stand,
  input  logic              crouch,
  input  logic              jump,
  input  logic              kick,
  input  logic              punch,
  input  logic              crouchpunch,
  input  logic              move,
  input  logic              block,
  input  logic              dead,
  input  logic              flip,
  input  logic              hit,
  input  logic              pal_we,
  input  logic [CW-1:0]     pal_char,
  input  logic [3:0]        pal_idx,
  input  logic [11:0]       pal_rgb,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_on
);

  localparam int unsigned LXW = $clog2(SPRITE_W);
  localparam int unsigned LYW = $clog2(SPRITE_H);
  localparam int unsigned FIW = (FRAMES_PER_POSE > 1) ? $clog2(FRAMES_PER_POSE) : 1;
  localparam int unsigned TW  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  localparam logic [3:0]     POSE_NONE  = 4'hF;
  localparam logic [3:0]     POSE_DEAD  = 4'd8;
  localparam logic [10:0]    BOX_W      = 11'(SPRITE_W << SCALE_SHIFT);
  localparam logic [10:0]    BOX_H      = 11'(SPRITE_H << SCALE_SHIFT);
  localparam logic [FIW-1:0] FRAME_LAST = FIW'(FRAMES_PER_POSE - 1);
  localparam logic [TW-1:0]  TICK_LAST  = TW'(FRAME_TICKS - 1);
  localparam logic [3:0]     TRANSP     = 4'(TRANSP_IDX);

  logic [3:0]        r_pose;
  logic [CW-1:0]     r_char;
  logic [TW-1:0]     r_tick;
  logic [FIW-1:0]    r_frame;

  logic [3:0]        w_pose_enc;
  logic              w_state_change;
  logic [10:0]       w_dx;
  logic [10:0]       w_dy;
  logic              w_in_box;
  logic [LXW-1:0]    w_lx;
  logic [LYW-1:0]    w_ly;
  logic [ROM_AW-1:0] w_addr;
  logic              w_flash;

  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_in_box1;
  logic              r_in_box2;
  logic [CW-1:0]     r_char1;
  logic [CW-1:0]     r_char2;
  logic              r_flash1;
  logic              r_flash2;
  logic [11:0]       r_rgb;
  logic              r_on;
  logic [11:0]       r_pal [NUM_CHARS*16];

  // Pose priority encoder, highest priority first.
  always_comb begin
    w_pose_enc = POSE_NONE;
    if (dead)              w_pose_enc = 4'd8;
    else if (block)        w_pose_enc = 4'd7;
    else if (kick)         w_pose_enc = 4'd3;
    else if (punch)        w_pose_enc = 4'd4;
    else if (crouchpunch)  w_pose_enc = 4'd5;
    else if (crouch)       w_pose_enc = 4'd1;
    else if (jump)         w_pose_enc = 4'd2;
    else if (move && stand) w_pose_enc = 4'd6;
    else if (stand)        w_pose_enc = 4'd0;
  end

  assign w_state_change = (w_pose_enc != r_pose) || (char_sel != r_char);

  // Pose, character and animation state only move at frame boundaries.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_pose  <= POSE_NONE;
      r_char  <= '0;
      r_tick  <= '0;
      r_frame <= '0;
    end else if (frame_tick) begin
      r_pose <= w_pose_enc;
      r_char <= char_sel;
      if (w_state_change) begin
        r_tick  <= '0;
        r_frame <= '0;
      end else if (r_tick == TICK_LAST) begin
        r_tick <= '0;
        if (r_pose == POSE_DEAD) begin
          if (r_frame != FRAME_LAST) r_frame <= r_frame + 1'b1;
        end else begin
          r_frame <= (r_frame == FRAME_LAST) ? '0 : r_frame + 1'b1;
        end
      end else begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

`ifdef SPRITE_HITFLASH_EN
  logic [2:0] r_flash_cnt;
  logic       r_tick_odd;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_flash_cnt <= '0;
      r_tick_odd  <= 1'b0;
    end else begin
      if (frame_tick) r_tick_odd <= ~r_tick_odd;
      if (hit) r_flash_cnt <= 3'd4;
      else if (frame_tick && (r_flash_cnt != 3'd0)) r_flash_cnt <= r_flash_cnt - 3'd1;
    end
  end

  assign w_flash = (r_flash_cnt != 3'd0) && r_tick_odd;
`else
  logic w_unused_hit;
  assign w_unused_hit = hit;
  assign w_flash      = 1'b0;
`endif

  // 11-bit differences make a scan position left of/above the sprite wrap to a large value.
  assign w_dx     = {1'b0, DrawX} - {1'b0, spritex};
  assign w_dy     = {1'b0, DrawY} - {1'b0, spritey};
  assign w_in_box = blank && (r_pose != POSE_NONE) && (w_dx < BOX_W) && (w_dy < BOX_H);
  assign w_lx     = flip ? w_dx[SCALE_SHIFT +: LXW] : ~w_dx[SCALE_SHIFT +: LXW];
  assign w_ly     = w_dy[SCALE_SHIFT +: LYW];

  assign w_addr = ROM_AW'((((32'(r_char) * 32'd9) + 32'(r_pose)) * FRAMES_PER_POSE
                           + 32'(r_frame)) * SPRITE_W * SPRITE_H
                          + 32'(w_ly) * SPRITE_W + 32'(w_lx));

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_rom_addr <= '0;
      r_in_box1  <= 1'b0;
      r_in_box2  <= 1'b0;
      r_char1    <= '0;
      r_char2    <= '0;
      r_flash1   <= 1'b0;
      r_flash2   <= 1'b0;
    end else begin
      if (w_in_box) r_rom_addr <= w_addr;
      r_in_box1 <= w_in_box;
      r_in_box2 <= r_in_box1;
      r_char1   <= r_char;
      r_char2   <= r_char1;
      r_flash1  <= w_flash;
      r_flash2  <= r_flash1;
    end
  end

  // Palette RAM has no reset; a same-edge write and read of one entry reads the old value.
  always_ff @(posedge vga_clk) begin
    if (pal_we) r_pal[{pal_char, pal_idx}] <= pal_rgb;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_rgb <= '0;
      r_on  <= 1'b0;
    end else if (r_in_box2 && (rom_q != TRANSP)) begin
      r_rgb <= r_flash2 ? 12'hFFF : r_pal[{r_char2, rom_q}];
      r_on  <= 1'b1;
    end else begin
      r_rgb <= '0;
      r_on  <= 1'b0;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign red       = r_rgb[11:8];
  assign green     = r_rgb[7:4];
  assign blue      = r_rgb[3:0];
  assign sprite_on = r_on;

endmodule
